// File: rtl/disp_vramrd_pkg.sv
// Shared types and defaults for the VRAM read master: AR/R state encodings,
// default burst geometry and the fixed top address bits.
package disp_vramrd_pkg;

   typedef enum logic [1:0] {
      AR_IDLE  = 2'd0,
      AR_ISSUE = 2'd1,
      AR_DRAIN = 2'd2
   } ar_state_t;

   typedef enum logic {
      R_READING  = 1'b0,
      R_WAITFIFO = 1'b1
   } r_state_t;

   localparam int         BURSTLEN_DEF   = 64;
   localparam int         BEAT_BYTES_DEF = 8;
   localparam int         BB             = BURSTLEN_DEF * BEAT_BYTES_DEF;
   localparam logic [2:0] ADDR_TOP_DEF   = 3'b001;

   function automatic int burst_bytes(input int burstlen, input int beat_bytes);
      return burstlen * beat_bytes;
   endfunction

endpackage

// File: rtl/disp_vramrd_gen2_if.sv
// AXI read address/data signals between the VRAM read master and the HP port.
// Handshakes: a transfer happens on a rising clock edge where VALID and READY are both high;
// once VALID is raised, it and its payload stay stable until that edge.
interface disp_vramrd_gen2_if;
   logic [31:0] ARADDR;
   logic [7:0]  ARLEN;
   logic        ARVALID;
   logic        ARREADY;
   logic        RLAST;
   logic        RVALID;
   logic        RREADY;

   modport master (
      output ARADDR, ARLEN, ARVALID, RREADY,
      input  ARREADY, RLAST, RVALID
   );

   modport slave (
      input  ARADDR, ARLEN, ARVALID, RREADY,
      output ARREADY, RLAST, RVALID
   );
endinterface

// File: rtl/disp_sync_edge.sv
// N-flop synchroniser; with EDGE=1 the output is a one-cycle rising-edge pulse
// of the synchronised level, otherwise the synchronised level itself.
module disp_sync_edge #(
   parameter int N    = 2,
   parameter bit EDGE = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic o
);

   logic [N-1:0] ff;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ff <= '0;
      else     ff <= {ff[N-2:0], d};
   end

   assign o = EDGE ? (ff[N-2] & ~ff[N-1]) : ff[N-1];

endmodule

// File: rtl/disp_vramrd_gen2.sv
// VRAM read master: fetches one frame from DDR into the pixel FIFO with a bounded
// number of outstanding bursts. Optional macro DISP_VRAMRD_STRIDE_EN adds strided line addressing.
module disp_vramrd_gen2
   import disp_vramrd_pkg::*;
#(
   parameter int         BURSTLEN   = BURSTLEN_DEF,
   parameter int         BEAT_BYTES = BEAT_BYTES_DEF,
   parameter int         MAX_OUTST  = 8,
   parameter int         FIFO_AW    = 10,
   parameter int         FIFO_HI    = 768,
   parameter int         FIFO_LO    = 512,
   parameter logic [2:0] ADDR_TOP   = ADDR_TOP_DEF
) (
   input  logic                 ACLK,
   input  logic                 ARST,
   disp_vramrd_gen2_if.master   axi,
   input  logic                 DSP_VSYNC_X,
   input  logic                 VRSTART,
   input  logic                 DISPON,
   input  logic [28:0]          DISPADDR,
   input  logic [28:0]          FRAME_BYTES,
`ifdef DISP_VRAMRD_STRIDE_EN
   input  logic [15:0]          LINE_BYTES,
   input  logic [15:0]          STRIDE,
`endif
   input  logic [FIFO_AW:0]     FIFO_LEVEL,
   output logic                 FIFOWR,
   output logic                 BUSY,
   output ar_state_t            dbg_ar_state,
   output r_state_t             dbg_r_state,
   output logic [4:0]           dbg_outst
);

   localparam int                BBL    = burst_bytes(BURSTLEN, BEAT_BYTES);
   localparam logic [28:0]       BB29   = 29'(BBL);
   localparam logic [4:0]        OUTMAX = 5'(MAX_OUTST);
   localparam logic [FIFO_AW:0]  LVL_HI = (FIFO_AW+1)'(FIFO_HI);
   localparam logic [FIFO_AW:0]  LVL_LO = (FIFO_AW+1)'(FIFO_LO);

   ar_state_t   ar_state, ar_state_n;
   r_state_t    r_state, r_state_n;
   logic [28:0] base, base_n, fsize, fsize_n, addrcnt, addrcnt_n;
   logic [28:0] araddr, araddr_n, off_n;
   logic        arvalid, arvalid_n;
   logic [4:0]  outst, outst_n;
   logic        start, vr_rise, flush, hs, rready, rdone;
`ifdef DISP_VRAMRD_STRIDE_EN
   logic [15:0] line_len, line_len_n, line_step, line_step_n, xoff, xoff_n;
   logic [28:0] line_base, line_base_n;
`endif

   disp_sync_edge #(.N(3), .EDGE(1'b1)) u_vrstart_sync (
      .clk(ACLK), .rst(ARST), .d(VRSTART), .o(vr_rise)
   );

   disp_sync_edge #(.N(2), .EDGE(1'b0)) u_vsync_sync (
      .clk(ACLK), .rst(ARST), .d(~DSP_VSYNC_X), .o(flush)
   );

   assign start  = DISPON & vr_rise;
   assign hs     = arvalid & axi.ARREADY;
   assign rready = (r_state == R_READING) | flush;
   // A stray RLAST with nothing outstanding must not underflow the counter.
   assign rdone  = axi.RLAST & axi.RVALID & rready & (outst != 5'd0);
   assign outst_n = outst + 5'(hs) - 5'(rdone);

   always_comb begin
      ar_state_n = ar_state;
      base_n     = base;
      fsize_n    = fsize;
      addrcnt_n  = addrcnt;
      araddr_n   = araddr;
      arvalid_n  = arvalid;
      off_n      = addrcnt;
`ifdef DISP_VRAMRD_STRIDE_EN
      line_len_n  = line_len;
      line_step_n = line_step;
      xoff_n      = xoff;
      line_base_n = line_base;
`endif
      case (ar_state)
         AR_IDLE: begin
            if (start) begin
               base_n     = DISPADDR;
               fsize_n    = FRAME_BYTES;
               addrcnt_n  = '0;
               ar_state_n = AR_ISSUE;
`ifdef DISP_VRAMRD_STRIDE_EN
               line_len_n  = LINE_BYTES;
               line_step_n = STRIDE;
               xoff_n      = '0;
               line_base_n = '0;
`endif
            end
         end
         AR_ISSUE: begin
            if (hs) begin
               addrcnt_n = addrcnt + BB29;
`ifdef DISP_VRAMRD_STRIDE_EN
               if (xoff + 16'(BBL) == line_len) begin
                  xoff_n      = '0;
                  line_base_n = line_base + 29'(line_step);
               end else begin
                  xoff_n = xoff + 16'(BBL);
               end
`endif
            end
`ifdef DISP_VRAMRD_STRIDE_EN
            off_n = line_base_n + 29'(xoff_n);
`else
            off_n = addrcnt_n;
`endif
            if (hs && (({1'b0, addrcnt} + 30'(BBL)) >= {1'b0, fsize})) begin
               arvalid_n  = 1'b0;
               ar_state_n = AR_DRAIN;
            end else if (!arvalid || hs) begin
               // Only a free slot is re-evaluated; a pending request is never withdrawn.
               if (flush || (addrcnt_n >= fsize)) begin
                  arvalid_n  = 1'b0;
                  ar_state_n = AR_DRAIN;
               end else begin
                  arvalid_n = (outst_n < OUTMAX);
                  araddr_n  = base + off_n;
               end
            end
         end
         AR_DRAIN: begin
            arvalid_n = 1'b0;
            if (outst == 5'd0) ar_state_n = AR_IDLE;
         end
         default: begin
            ar_state_n = AR_IDLE;
            arvalid_n  = 1'b0;
         end
      endcase
   end

   always_comb begin
      r_state_n = r_state;
      if (flush)                                        r_state_n = R_READING;
      else if (r_state == R_READING  && FIFO_LEVEL >= LVL_HI) r_state_n = R_WAITFIFO;
      else if (r_state == R_WAITFIFO && FIFO_LEVEL <  LVL_LO) r_state_n = R_READING;
   end

   always_ff @(posedge ACLK or posedge ARST) begin
      if (ARST) begin
         ar_state <= AR_IDLE;
         r_state  <= R_READING;
         base     <= '0;
         fsize    <= '0;
         addrcnt  <= '0;
         araddr   <= '0;
         arvalid  <= 1'b0;
         outst    <= '0;
`ifdef DISP_VRAMRD_STRIDE_EN
         line_len  <= '0;
         line_step <= '0;
         xoff      <= '0;
         line_base <= '0;
`endif
      end else begin
         ar_state <= ar_state_n;
         r_state  <= r_state_n;
         base     <= base_n;
         fsize    <= fsize_n;
         addrcnt  <= addrcnt_n;
         araddr   <= araddr_n;
         arvalid  <= arvalid_n;
         outst    <= outst_n;
`ifdef DISP_VRAMRD_STRIDE_EN
         line_len  <= line_len_n;
         line_step <= line_step_n;
         xoff      <= xoff_n;
         line_base <= line_base_n;
`endif
      end
   end

   assign axi.ARADDR  = {ADDR_TOP, araddr};
   assign axi.ARLEN   = 8'(BURSTLEN - 1);
   assign axi.ARVALID = arvalid;
   assign axi.RREADY  = rready;
   assign FIFOWR      = (r_state == R_READING) & axi.RVALID & ~flush;
   assign BUSY        = (ar_state != AR_IDLE) | (outst != 5'd0);
   assign dbg_ar_state = ar_state;
   assign dbg_r_state  = r_state;
   assign dbg_outst    = outst;

endmodule
